// File: rtl/alu_pkt_rx.sv
// Serial packet receiver for an ALU front end.
// Frames are zero or more data packets followed by one command packet.
// Each packet is 11 bits, MSB first: start(0), type, 8 payload bits, stop(1).
// A completed command packet publishes operands, opcode and an error code
// through a valid/ready holding register; results arriving while the
// register is still occupied are dropped and flagged as an overrun.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// SHIFT  | collecting type, payload and stop bits of a packet
// RESYNC | stop bit was 0, waiting for the line to return high
module alu_pkt_rx #(
  parameter int          OPW     = 32,
  parameter int          NOPS    = 2,
  parameter logic [7:0]  OP_MASK = 8'b0011_0011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  output logic [NOPS*OPW-1:0]  ops_o,
  output logic [2:0]           op_o,
  output logic [1:0]           err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int         W  = NOPS * OPW;
  localparam logic [5:0] NB = 6'(W / 8);

  typedef enum logic [1:0] {IDLE, SHIFT, RESYNC} state_t;

  state_t       state_q, state_d;
  logic [3:0]   bit_cnt_q;
  logic [8:0]   pkt_q;
  logic [3:0]   bcnt_q;
  logic [3:0]   crc_q;
  logic         in_frame_q;
  logic [W-1:0] sh_q;

  logic         last_bit, pkt_ok, pkt_bad, data_done, cmd_done;
  logic [3:0]   crc_data, crc_cmd;
  logic [1:0]   err_d;
  logic [W+7:0] sh_cat;
  logic [W-1:0] sh_next;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == 4'd10);
  assign pkt_ok    = last_bit && sin;
  assign pkt_bad   = last_bit && !sin;
  assign data_done = pkt_ok && !pkt_q[8];
  assign cmd_done  = pkt_ok && pkt_q[8];
  assign sh_cat    = {sh_q, pkt_q[7:0]};
  assign sh_next   = in_frame_q ? sh_cat[W-1:0] : W'(pkt_q[7:0]);

  // CRC advanced over a whole data byte, and over the {1, OP} command tail
  always_comb begin
    crc_data = crc_q;
    for (int i = 7; i >= 0; i--) crc_data = crc_step(crc_data, pkt_q[i]);
    crc_cmd = crc_step(crc_q, 1'b1);
    for (int i = 6; i >= 4; i--) crc_cmd = crc_step(crc_cmd, pkt_q[i]);
  end

  // Error decision for a completing command, highest priority first
  always_comb begin
    err_d = 2'b00;
    if ({2'b00, bcnt_q} != NB)        err_d = 2'b01;
    else if (crc_cmd != pkt_q[3:0])   err_d = 2'b10;
    else if (!OP_MASK[pkt_q[6:4]])    err_d = 2'b11;
  end

  // Packet FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Packet FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!sin) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == 4'd10) state_d = sin ? IDLE : RESYNC;
      RESYNC:  if (sin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and packet shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 4'd0;
      pkt_q     <= 9'd0;
    end else if (state_q == IDLE && !sin) begin
      bit_cnt_q <= 4'd1;
    end else if (state_q == SHIFT) begin
      bit_cnt_q <= bit_cnt_q + 4'd1;
      if (bit_cnt_q <= 4'd9) pkt_q <= {pkt_q[7:0], sin};
    end
  end

  // Frame accumulation: byte count, running CRC and operand shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q      <= 4'd0;
      crc_q       <= 4'd0;
      in_frame_q  <= 1'b0;
      sh_q        <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= pkt_bad;
      if (pkt_bad || cmd_done) begin
        bcnt_q     <= 4'd0;
        crc_q      <= 4'd0;
        in_frame_q <= 1'b0;
      end else if (data_done) begin
        if (bcnt_q != 4'd15) bcnt_q <= bcnt_q + 4'd1;
        crc_q      <= crc_data;
        sh_q       <= sh_next;
        in_frame_q <= 1'b1;
      end
    end
  end

  // Result holding register with valid/ready handshake and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      ops_o     <= '0;
      op_o      <= 3'd0;
      err_o     <= 2'b00;
      overrun_o <= 1'b0;
    end else if (cmd_done && (!valid_o || ready_i)) begin
      valid_o <= 1'b1;
      ops_o   <= in_frame_q ? sh_q : '0;
      op_o    <= pkt_q[6:4];
      err_o   <= err_d;
    end else if (cmd_done) begin
      overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pkt_rx.sv
// Self-checking bench for alu_pkt_rx: directed frames plus randomized frames
// compared against a reference model built from the frame rules.
module tb_alu_pkt_rx;

  localparam logic [7:0] MASK = 8'b0011_0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        sin2 = 1'b1;
  logic        ready = 1'b1;
  logic [63:0] ops;
  logic [2:0]  op;
  logic [1:0]  err;
  logic        valid, ferr, ovr;
  logic [47:0] ops2;
  logic [2:0]  op2;
  logic [1:0]  err2;
  logic        valid2, ferr2, ovr2;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pkt_rx u_dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .ops_o(ops), .op_o(op), .err_o(err),
    .valid_o(valid), .ready_i(ready), .frame_err_o(ferr), .overrun_o(ovr)
  );

  alu_pkt_rx #(.OPW(16), .NOPS(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sin(sin2), .ops_o(ops2), .op_o(op2), .err_o(err2),
    .valid_o(valid2), .ready_i(ready), .frame_err_o(ferr2), .overrun_o(ovr2)
  );

  always #5 clk = ~clk;

  // Reference CRC: remainder of message * x^4 divided by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [7:0] b[$], input logic [2:0] o);
    bit q[$];
    logic [4:0] r = 5'd0;
    foreach (b[i]) for (int k = 7; k >= 0; k--) q.push_back(b[i][k]);
    q.push_back(1'b1);
    for (int k = 2; k >= 0; k--) q.push_back(o[k]);
    repeat (4) q.push_back(1'b0);
    foreach (q[i]) begin
      r = {r[3:0], q[i]};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [1:0] ref_err(input logic [7:0] b[$], input logic [2:0] o,
                                         input logic [3:0] c, input int nb);
    int n;
    n = (b.size() > 15) ? 15 : b.size();
    if (n != nb) return 2'b01;
    if (c != ref_crc(b, o)) return 2'b10;
    if (!MASK[o]) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [63:0] ref_ops(input logic [7:0] b[$]);
    logic [63:0] v = 64'd0;
    foreach (b[i]) v = (v << 8) | 64'(b[i]);
    return v;
  endfunction

  task automatic send_pkt(input bit which, input logic typ, input logic [7:0] pl, input logic stop);
    logic [10:0] p;
    p = {1'b0, typ, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      if (which) sin2 = p[i];
      else       sin  = p[i];
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] b[$], input logic [2:0] o, input logic [3:0] c);
    foreach (b[i]) send_pkt(which, 1'b0, b[i], 1'b1);
    send_pkt(which, 1'b1, {1'b0, o, c}, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin  = 1'b1;
      sin2 = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({valid, ops, op, err, ferr, ovr} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b ops=%h op=%0d err=%0d fe=%0b ov=%0b want all 0",
               valid, ops, op, err, ferr, ovr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    n_tests++;
    if ({valid, ferr, ovr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: got v=%0b fe=%0b ov=%0b want 000", valid, ferr, ovr);
    end
  endtask

  task automatic test_good_frame;
    logic [7:0] b[$];
    b = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame(1'b0, b, 3'd0, ref_crc(b, 3'd0));
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL good_latency: valid=%0b at stop-bit sample, want 0", valid);
    end
    idle(1);
    n_tests++;
    if ({valid, ops, op, err} !== {1'b1, 64'h00000002_00000001, 3'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL good_result: got v=%0b ops=%h op=%0d err=%0d want v=1 ops=0000000200000001 op=0 err=0",
               valid, ops, op, err);
    end
    idle(1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL good_accept: valid=%0b after acceptance, want 0", valid);
    end
  endtask

  task automatic test_err_codes;
    logic [7:0] b[$];
    logic [3:0] c;
    b = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, b, 3'd0, ref_crc(b, 3'd0));
    idle(1);
    n_tests++;
    if ({valid, err} !== {1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL err_data: got v=%0b err=%0d want v=1 err=1", valid, err);
    end
    idle(2);
    b.push_back(8'h01);
    c = ~ref_crc(b, 3'd0);
    send_frame(1'b0, b, 3'd0, c);
    idle(1);
    n_tests++;
    if ({valid, err} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL err_crc: got v=%0b err=%0d want v=1 err=2", valid, err);
    end
    idle(2);
    send_frame(1'b0, b, 3'd2, ref_crc(b, 3'd2));
    idle(1);
    n_tests++;
    if ({valid, op, err} !== {1'b1, 3'd2, 2'b11}) begin
      n_fail++;
      $display("FAIL err_op: got v=%0b op=%0d err=%0d want v=1 op=2 err=3", valid, op, err);
    end
    idle(2);
  endtask

  task automatic test_stop_err;
    logic [7:0] b[$];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(1'b0, 1'b0, 8'hA5, 1'b1);
    send_pkt(1'b0, 1'b0, 8'h5A, 1'b1);
    send_pkt(1'b0, 1'b0, 8'h3C, 1'b0);
    idle(1);
    n_tests++;
    if ({ferr, valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL stop_err_pulse: got fe=%0b v=%0b want fe=1 v=0", ferr, valid);
    end
    idle(1);
    n_tests++;
    if ({ferr, valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_err_width: got fe=%0b v=%0b want fe=0 v=0", ferr, valid);
    end
    send_frame(1'b0, b, 3'd1, ref_crc(b, 3'd1));
    idle(1);
    n_tests++;
    if ({valid, ops, op, err} !== {1'b1, 64'h11223344_55667788, 3'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL stop_err_recover: got v=%0b ops=%h op=%0d err=%0d want v=1 ops=1122334455667788 op=1 err=0",
               valid, ops, op, err);
    end
    idle(2);
  endtask

  task automatic test_random;
    logic [7:0] b[$];
    logic [2:0] o;
    logic [3:0] c;
    int nb;
    for (int t = 0; t < 25; t++) begin
      b.delete();
      case ($urandom_range(0, 3))
        0, 1:    nb = 8;
        2:       nb = ($urandom_range(0, 1) != 0) ? 7 : 9;
        default: nb = $urandom_range(0, 12);
      endcase
      repeat (nb) b.push_back(8'($urandom));
      o = 3'($urandom);
      c = ref_crc(b, o);
      if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
      send_frame(1'b0, b, o, c);
      idle(1);
      n_tests++;
      if ({valid, ops, op, err, ovr} !== {1'b1, ref_ops(b), o, ref_err(b, o, c, 8), 1'b0}) begin
        n_fail++;
        $display("FAIL random_%0d: got v=%0b ops=%h op=%0d err=%0d ov=%0b want v=1 ops=%h op=%0d err=%0d ov=0",
                 t, valid, ops, op, err, ovr, ref_ops(b), o, ref_err(b, o, c, 8));
      end
      idle(1 + $urandom_range(0, 2));
    end
  endtask

  task automatic test_overrun;
    logic [7:0] a[$];
    logic [7:0] b[$];
    a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    b = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8};
    ready = 1'b0;
    send_frame(1'b0, a, 3'd0, ref_crc(a, 3'd0));
    idle(1);
    send_frame(1'b0, b, 3'd4, ref_crc(b, 3'd4));
    idle(1);
    n_tests++;
    if ({valid, ops, op, ovr} !== {1'b1, 64'h01020304_05060708, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_hold: got v=%0b ops=%h op=%0d ov=%0b want v=1 ops=0102030405060708 op=0 ov=1",
               valid, ops, op, ovr);
    end
    ready = 1'b1;
    idle(1);
    n_tests++;
    if ({valid, ovr} !== 2'b01) begin
      n_fail++;
      $display("FAIL overrun_sticky: got v=%0b ov=%0b want v=0 ov=1", valid, ovr);
    end
    idle(2);
  endtask

  task automatic test_same_cycle;
    logic [7:0] a[$];
    logic [7:0] b[$];
    a = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    b = '{8'hC0, 8'hDE, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h12, 8'h34};
    ready = 1'b0;
    send_frame(1'b0, a, 3'd5, ref_crc(a, 3'd5));
    idle(1);
    send_frame(1'b0, b, 3'd1, ref_crc(b, 3'd1));
    ready = 1'b1;
    idle(1);
    n_tests++;
    if ({valid, ops, op, err} !== {1'b1, 64'hC0DE0001_BEEF1234, 3'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL same_cycle_load: got v=%0b ops=%h op=%0d err=%0d want v=1 ops=c0de0001beef1234 op=1 err=0",
               valid, ops, op, err);
    end
    idle(1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_drop: valid=%0b want 0", valid);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b[$];
    logic [10:0] p;
    b = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 1'b0, 8'h99, 1'b1);
    p = {1'b0, 1'b0, 8'hAA, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      @(negedge clk);
      sin = p[i];
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({valid, ops, op, err, ferr, ovr} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%0b ops=%h op=%0d err=%0d fe=%0b ov=%0b want all 0",
               valid, ops, op, err, ferr, ovr);
    end
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(1'b0, b, 3'd0, ref_crc(b, 3'd0));
    idle(1);
    n_tests++;
    if ({valid, ops, err} !== {1'b1, 64'h00000002_00000001, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid_next: got v=%0b ops=%h err=%0d want v=1 ops=0000000200000001 err=0",
               valid, ops, err);
    end
    idle(2);
  endtask

  task automatic test_wide_cfg;
    logic [7:0] b[$];
    logic [63:0] e;
    repeat (6) b.push_back(8'($urandom));
    e = ref_ops(b);
    send_frame(1'b1, b, 3'd4, ref_crc(b, 3'd4));
    idle(1);
    n_tests++;
    if ({valid2, ops2, op2, err2} !== {1'b1, e[47:0], 3'd4, 2'b00}) begin
      n_fail++;
      $display("FAIL cfg16x3: got v=%0b ops=%h op=%0d err=%0d want v=1 ops=%h op=4 err=0",
               valid2, ops2, op2, err2, e[47:0]);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_codes();
    test_stop_err();
    test_random();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_wide_cfg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
